// File: rtl/if_fetch_stage_if.sv
// Signal bundle between the fetch stage and its neighbours:
// hazard/control inputs, instruction memory, and the IF/ID register outputs.
interface if_fetch_stage_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             flush;
    logic             pc_src;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_data;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] if_id_npc;
    logic [WIDTH-1:0] if_id_instr;
    logic             if_id_valid;
    logic [WIDTH-1:0] fetch_count;

    // Surrounding pipeline: drives control and memory data, observes the stage.
    modport master (
        output stall, flush, pc_src, branch_target, imem_data,
        input  imem_addr, pc_out, if_id_npc, if_id_instr, if_id_valid, fetch_count
    );

    // Fetch stage itself.
    modport slave (
        input  stall, flush, pc_src, branch_target, imem_data,
        output imem_addr, pc_out, if_id_npc, if_id_instr, if_id_valid, fetch_count
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, PC+1 / redirect selection, and the
// IF/ID pipeline register with stall, flush and a fetched-instruction counter.
module if_fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic            clk,
    input logic            rst,
    if_fetch_stage_if.slave bus
);
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_npc;
    logic [WIDTH-1:0] r_instr;
    logic             r_valid;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_npc;

    // Word-addressed sequential PC; wraps silently at the top of the space.
    assign w_npc = r_pc + WIDTH'(1);

    // Redirect wins over stall so a taken branch is never lost behind a hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (bus.pc_src) begin
            r_pc <= bus.branch_target;
        end else if (!bus.stall) begin
            r_pc <= w_npc;
        end
    end

    // if_id_valid qualifies the IF/ID fields: 1 = real instruction, 0 = bubble.
    // There is no back-pressure other than stall, which freezes all fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_npc   <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_npc   <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_npc   <= w_npc;
            r_instr <= bus.imem_data;
            r_valid <= 1'b1;
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.pc_out      = r_pc;
    assign bus.if_id_npc   = r_npc;
    assign bus.if_id_instr = r_instr;
    assign bus.if_id_valid = r_valid;
    assign bus.fetch_count = r_count;
endmodule
